// File: rtl/tt_axi_read_master.sv
// AXI4-lite read master for the times-table memory: one (a,b) request in,
// one AR/R read out, 6-bit product plus error flag back to the consumer.
module tt_axi_read_master #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        a,
  input  logic [2:0]        b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [5:0]        result,
  output logic              err,
  output logic [CNT_W-1:0]  txn_count,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t              r_state, w_next;
  logic                r_req_ready, r_arvalid, r_rready, r_res_valid;
  logic [ADDR_W-1:0]   r_araddr;
  logic [5:0]          r_result;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept, w_rhs;
  logic                w_unused_rdata;

  // Upper read-data bits carry nothing for this memory.
  assign w_unused_rdata = ^m_axi_rdata[31:6];

  // Accept is gated by the registered ready so nothing is taken in the
  // first cycle after reset release, when req_ready is still low.
  assign w_accept = (r_state == IDLE) && req_valid && r_req_ready;
  assign w_rhs    = (r_state == DATA) && m_axi_rvalid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept)      w_next = ADDR;
      ADDR: if (m_axi_arready) w_next = DATA;
      DATA: if (m_axi_rvalid)  w_next = RESP;
      RESP: if (res_ready)     w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode, so
  // they are glitch-free, state-aligned and read 0 throughout reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_res_valid <= 1'b0;
      r_araddr    <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == IDLE);
      r_arvalid   <= (w_next == ADDR);
      r_rready    <= (w_next == DATA);
      r_res_valid <= (w_next == RESP);
      if (w_accept)
        r_araddr <= ADDR_W'({a, b, 2'b00});
      if (w_rhs) begin
        r_result <= m_axi_rdata[5:0];
        r_err    <= (m_axi_rresp != 2'b00);
        if (r_cnt != '1)
          r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign req_ready     = r_req_ready;
  assign res_valid     = r_res_valid;
  assign result        = r_result;
  assign err           = r_err;
  assign txn_count     = r_cnt;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_tt_axi_read_master.sv
// Bench for tt_axi_read_master: randomized producer/slave/consumer with a
// transaction-level reference model, plus directed literal checks.
module tb_tt_axi_read_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  a = '0, b = '0;
  logic        res_ready = 1'b0;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;

  logic        req_ready, res_valid, err, arvalid, rready;
  logic [5:0]  result;
  logic [15:0] txn_count;
  logic [31:0] araddr;

  logic        req_ready2, res_valid2, err2, arvalid2, rready2;
  logic [5:0]  result2;
  logic [1:0]  txn_count2;
  logic [31:0] araddr2;

  always #5 clk = ~clk;

  tt_axi_read_master #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .err(err), .txn_count(txn_count),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready));

  // Narrow-counter twin, fed identically, to exercise saturation.
  tt_axi_read_master #(.ADDR_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .a(a), .b(b), .res_valid(res_valid2), .res_ready(res_ready),
    .result(result2), .err(err2), .txn_count(txn_count2),
    .m_axi_araddr(araddr2), .m_axi_arvalid(arvalid2), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus knobs
  bit rnd_dly   = 1'b0;
  int fix_ar    = 0;
  int fix_r     = 0;
  int resp_mode = 0;   // -1 random, else forced rresp
  int rr_mode   = 0;   // 0 tied high, 1 random, 2 fixed delay after res_valid
  int rr_delay  = 0;

  function automatic int ar_dly();
    return rnd_dly ? int'($urandom_range(0, 3)) : fix_ar;
  endfunction
  function automatic int r_dly();
    return rnd_dly ? int'($urandom_range(0, 3)) : fix_r;
  endfunction

  // AXI slave: times-table memory with programmable AR/R delays
  initial begin
    int cnt, phase, pa, pb;
    bit ar_pend, r_pend;
    logic [31:0] addr;
    cnt = 0; phase = 0; ar_pend = 0; r_pend = 0; addr = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        arready = 0; rvalid = 0; phase = 0; ar_pend = 0; r_pend = 0; cnt = ar_dly();
      end else begin
        if (ar_pend) begin ar_pend = 0; arready = 0; phase = 1; cnt = r_dly(); end
        if (r_pend)  begin r_pend = 0; rvalid = 0; phase = 0; cnt = ar_dly(); end
        if (phase == 0) begin
          if (arvalid) begin
            if (cnt == 0) begin arready = 1; ar_pend = 1; addr = araddr; end
            else cnt--;
          end
        end else if (rready) begin
          if (cnt == 0) begin
            pa = int'(addr[7:5]); pb = int'(addr[4:2]);
            rdata  = {26'($urandom), 6'(pa * pb)};
            rresp  = (resp_mode < 0) ? 2'($urandom) : 2'(resp_mode);
            rvalid = 1; r_pend = 1;
          end else cnt--;
        end
      end
    end
  end

  // Consumer
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: res_ready = 1;
        1: res_ready = 1'($urandom);
        default: begin
          if (res_valid) begin
            if (rc == 0) res_ready = 1;
            else begin rc--; res_ready = 0; end
          end else begin
            res_ready = 0; rc = rr_delay;
          end
        end
      endcase
    end
  end

  // Reference model: one transaction at a time, tracked by the values that
  // the rules say must appear; compared on every falling edge.
  bit          busy = 0, have_r = 0, arv_stall = 0, prev_rst_low = 1;
  int          cur_a = 0, cur_b = 0, n_ar = 0, exp_cnt = 0, exp_cnt2 = 0;
  bit          exp_err = 0;
  logic [31:0] held_addr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ctrl", 64'({req_ready, res_valid, err, arvalid, rready}), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_cnt", 64'(txn_count), 64'd0);
      chk("rst_addr", 64'(araddr), 64'd0);
      busy = 0; have_r = 0; arv_stall = 0; exp_cnt = 0; exp_cnt2 = 0; prev_rst_low = 1;
    end else begin
      chk("ar_r_excl", 64'(arvalid && rready), 64'd0);
      if (!prev_rst_low) chk("req_ready", 64'(req_ready), 64'(!busy));
      chk("txn_count", 64'(txn_count), 64'(exp_cnt));
      chk("txn_count_sat", 64'(txn_count2), 64'(exp_cnt2));
      if (arv_stall) chk("araddr_hold", 64'(araddr), 64'(held_addr));
      if (arvalid) chk("arvalid_busy", 64'(busy && !have_r), 64'd1);
      if (arvalid && arready) begin
        chk("araddr", 64'(araddr), 64'((cur_a << 5) | (cur_b << 2)));
        n_ar++;
      end
      if (rvalid && rready) begin
        have_r  = 1;
        exp_err = (rresp != 2'b00);
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
      if (res_valid) begin
        chk("res_after_r", 64'(busy && have_r), 64'd1);
        chk("result", 64'(result), 64'(cur_a * cur_b));
        chk("err", 64'(err), 64'(exp_err));
        if (res_ready) begin
          chk("one_ar_per_req", 64'(n_ar), 64'd1);
          busy = 0;
        end
      end
      if (req_valid && req_ready) begin
        chk("accept_idle", 64'(busy), 64'd0);
        busy = 1; have_r = 0; n_ar = 0; cur_a = int'(a); cur_b = int'(b);
      end
      arv_stall = arvalid && !arready;
      held_addr = araddr;
      prev_rst_low = 0;
    end
  end

  task automatic do_req(input logic [2:0] ia, input logic [2:0] ib);
    int n; bit hs;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1; a = ia; b = ib;
    do begin @(negedge clk); hs = req_ready; n++; end while (!hs && n < 500);
    chk("req_accept_timeout", 64'(hs), 64'd1);
    @(posedge clk); #1;
    req_valid = 0; a = 3'($urandom); b = 3'($urandom);
  endtask

  task automatic get_res(output logic [5:0] r, output logic e);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 500);
    chk("res_timeout", 64'(res_valid), 64'd1);
    r = result; e = err;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 2000);
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 0;
    repeat (3) @(posedge clk);
    #1; rst = 1;
    repeat (2) @(posedge clk);
  endtask

  logic [5:0] r;
  logic       e;
  int         sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1; rst = 1;
    repeat (2) @(posedge clk);

    // Single read, minimum latency, literal expectations
    rnd_dly = 0; fix_ar = 0; fix_r = 0; resp_mode = 0; rr_mode = 0;
    #1; req_valid = 1; a = 3; b = 5;
    chk("c0_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1; req_valid = 0;
    chk("c1_arvalid", 64'(arvalid), 64'd1);
    chk("c1_araddr", 64'(araddr), 64'h74);
    chk("c1_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("c2_rready", 64'(rready), 64'd1);
    chk("c2_arvalid", 64'(arvalid), 64'd0);
    @(posedge clk); #1;
    chk("c3_res_valid", 64'(res_valid), 64'd1);
    chk("c3_result", 64'(result), 64'd15);
    chk("c3_err", 64'(err), 64'd0);
    chk("c3_cnt", 64'(txn_count), 64'd1);
    wait_idle();

    // Error response then clearing OKAY read
    resp_mode = 2;
    do_req(3'd7, 3'd7); get_res(r, e);
    chk("slverr_result", 64'(r), 64'd49);
    chk("slverr_err", 64'(e), 64'd1);
    chk("slverr_cnt", 64'(txn_count), 64'd2);
    resp_mode = 0;
    do_req(3'd1, 3'd1); get_res(r, e);
    chk("okay_err", 64'(e), 64'd0);
    chk("okay_result", 64'(r), 64'd1);
    wait_idle();

    // Full sweep from reset
    do_reset();
    for (int i = 0; i < 64; i++) do_req(3'(i >> 3), 3'(i & 7));
    wait_idle();
    chk("sweep_cnt", 64'(txn_count), 64'd64);
    chk("sweep_cnt_sat", 64'(txn_count2), 64'd3);

    // Fixed stalls on every channel, with a second request held waiting
    fix_ar = 4; fix_r = 3; rr_mode = 2; rr_delay = 2;
    do_req(3'd5, 3'd6);
    do_req(3'd6, 3'd3);
    wait_idle();

    // Randomized traffic
    rnd_dly = 1; rr_mode = 1; resp_mode = -1;
    for (int i = 0; i < 300; i++) begin
      do_req(3'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    wait_idle();

    // Reset while in DATA
    rnd_dly = 0; fix_ar = 0; fix_r = 20; rr_mode = 0; resp_mode = 0;
    do_req(3'd4, 3'd5);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!rready && n < 100);
      chk("reach_data", 64'(rready), 64'd1);
    end
    @(posedge clk); #1; rst = 0; #1;
    chk("midrst_ctrl", 64'({req_ready, res_valid, err, arvalid, rready}), 64'd0);
    chk("midrst_cnt", 64'(txn_count), 64'd0);
    chk("midrst_addr", 64'(araddr), 64'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1; fix_r = 0;
    repeat (2) @(posedge clk);
    do_req(3'd2, 3'd6); get_res(r, e);
    chk("postrst_result", 64'(r), 64'd12);
    chk("postrst_cnt", 64'(txn_count), 64'd1);
    wait_idle();

    // Saturation on the narrow counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_req(3'(i), 3'(i + 1)); get_res(r, e);
      chk("sat_seq", 64'(txn_count2), 64'(sat_exp[i]));
      chk("wide_seq", 64'(txn_count), 64'(i + 1));
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
